rv_decode_stage: RTL

//  Registered RV32/RV64 instruction decoder for the ID stage; successor to the flag-driven control decoder.

---
 rtl/rv_decode_stage_if.sv | 51 +++++
 rtl/rv_decode_stage.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_decode_stage_if.sv
// Fetch -> decode -> execute handshake and decoded-bundle bus for rv_decode_stage.
//   in_valid/in_ready/in_instr/in_pc : fetch side, valid/ready capture
//   flush                            : kill held and incoming instruction
//   out_valid/out_ready + bundle     : execute side, registered decoded fields
// Modports: slave = decode stage, master = surrounding pipeline / testbench.
interface rv_decode_stage_if #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned PC_W       = 32,
    parameter int unsigned ALU_CTRL_W = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           in_instr;
    logic [PC_W-1:0]       in_pc;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    logic [PC_W-1:0]       out_pc;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic [2:0]            fun3;
    logic [XLEN-1:0]       imm;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic                  operand_b;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic                  mem_en;
    logic                  load;
    logic                  store;
    logic                  branch;
    logic                  jal;
    logic                  jalr;
    logic [1:0]            imm_sel;
    logic [1:0]            rd_sel;
    logic                  illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, rs1, rs2, rd, fun3, imm, alu_control,
               operand_b, reg_write, mem_to_reg, mem_en, load, store, branch, jal, jalr,
               imm_sel, rd_sel, illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, rs1, rs2, rd, fun3, imm, alu_control,
               operand_b, reg_write, mem_to_reg, mem_en, load, store, branch, jal, jalr,
               imm_sel, rd_sel, illegal
    );
endinterface

// File: rtl/rv_decode_stage.sv
// Registered RV32/RV64 instruction decoder for the ID stage.
// Decodes raw instructions (opcode class, fun3/fun7 legality, sign-extended
// immediate, ALU code) into a single-entry valid/ready pipeline register.
// Ports:
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   bus (slave)   : fetch handshake, flush, execute handshake and decoded bundle
//   decoded_cnt   : count of legal bundles handed to execute (wraps)
// Optional feature: define RV_MEXT_EN to decode the M extension (fun7 0000001).
module rv_decode_stage #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned PC_W       = 32,
    parameter int unsigned ALU_CTRL_W = 5,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    rv_decode_stage_if.slave bus,
    output logic [CNT_W-1:0] decoded_cnt
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = ALU_CTRL_W'(0);
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = ALU_CTRL_W'(1);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = ALU_CTRL_W'(2);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = ALU_CTRL_W'(3);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = ALU_CTRL_W'(4);
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = ALU_CTRL_W'(5);
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = ALU_CTRL_W'(6);
    localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = ALU_CTRL_W'(7);
    localparam logic [ALU_CTRL_W-1:0] ALU_OR   = ALU_CTRL_W'(8);
    localparam logic [ALU_CTRL_W-1:0] ALU_AND  = ALU_CTRL_W'(9);
`ifdef RV_MEXT_EN
    localparam logic [ALU_CTRL_W-1:0] ALU_MUL  = ALU_CTRL_W'(10);
`endif

    typedef struct packed {
        logic [PC_W-1:0]       pc;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [4:0]            rd;
        logic [2:0]            fun3;
        logic [XLEN-1:0]       imm;
        logic [ALU_CTRL_W-1:0] alu_control;
        logic                  operand_b;
        logic                  reg_write;
        logic                  mem_to_reg;
        logic                  mem_en;
        logic                  load;
        logic                  store;
        logic                  branch;
        logic                  jal;
        logic                  jalr;
        logic [1:0]            imm_sel;
        logic [1:0]            rd_sel;
        logic                  illegal;
    } bundle_t;

    logic [31:0]      instr;
    logic [6:0]       opcode;
    logic [2:0]       fun3;
    logic [6:0]       fun7;
    logic [XLEN-1:0]  imm_i, imm_s, imm_b, imm_j;
    logic             slli_ok, srxi_ok;
    bundle_t          dec_c;
    bundle_t          bundle_q, bundle_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_c, capture_c, handoff_c;

    assign instr  = bus.in_instr;
    assign opcode = instr[6:0];
    assign fun3   = instr[14:12];
    assign fun7   = instr[31:25];

    // Immediate formats, all sign-extended from instr[31]
    assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Shift-immediate upper bits; on RV64 instr[25] is shamt[5] and is free
    assign slli_ok = (XLEN == 64) ? (instr[31:26] == 6'd0) : (instr[31:25] == 7'd0);
    assign srxi_ok = !instr[31] && (instr[29:26] == 4'd0) && ((XLEN == 64) || !instr[25]);

    // Instruction decode of the incoming fetch word
    always_comb begin
        dec_c             = '0;
        dec_c.pc          = bus.in_pc;
        dec_c.rs1         = instr[19:15];
        dec_c.rs2         = instr[24:20];
        dec_c.rd          = instr[11:7];
        dec_c.fun3        = fun3;
        dec_c.alu_control = ALU_ADD;
        case (opcode)
            OP_R: begin
                dec_c.reg_write = 1'b1;
                case (fun7)
                    7'b0000000: begin
                        case (fun3)
                            3'b000:  dec_c.alu_control = ALU_ADD;
                            3'b001:  dec_c.alu_control = ALU_SLL;
                            3'b010:  dec_c.alu_control = ALU_SLT;
                            3'b011:  dec_c.alu_control = ALU_SLTU;
                            3'b100:  dec_c.alu_control = ALU_XOR;
                            3'b101:  dec_c.alu_control = ALU_SRL;
                            3'b110:  dec_c.alu_control = ALU_OR;
                            default: dec_c.alu_control = ALU_AND;
                        endcase
                    end
                    7'b0100000: begin
                        if (fun3 == 3'b000)      dec_c.alu_control = ALU_SUB;
                        else if (fun3 == 3'b101) dec_c.alu_control = ALU_SRA;
                        else                     dec_c.illegal     = 1'b1;
                    end
`ifdef RV_MEXT_EN
                    // MUL..REMU are consecutive codes in fun3 order
                    7'b0000001: dec_c.alu_control = ALU_MUL + ALU_CTRL_W'(fun3);
`endif
                    default: dec_c.illegal = 1'b1;
                endcase
            end
            OP_I: begin
                dec_c.reg_write = 1'b1;
                dec_c.operand_b = 1'b1;
                case (fun3)
                    3'b000:  dec_c.alu_control = ALU_ADD;
                    3'b010:  dec_c.alu_control = ALU_SLT;
                    3'b011:  dec_c.alu_control = ALU_SLTU;
                    3'b100:  dec_c.alu_control = ALU_XOR;
                    3'b110:  dec_c.alu_control = ALU_OR;
                    3'b111:  dec_c.alu_control = ALU_AND;
                    3'b001: begin
                        dec_c.alu_control = ALU_SLL;
                        dec_c.illegal     = !slli_ok;
                    end
                    default: begin
                        dec_c.alu_control = instr[30] ? ALU_SRA : ALU_SRL;
                        dec_c.illegal     = !srxi_ok;
                    end
                endcase
            end
            OP_LOAD: begin
                dec_c.reg_write  = 1'b1;
                dec_c.operand_b  = 1'b1;
                dec_c.mem_to_reg = 1'b1;
                dec_c.load       = 1'b1;
                dec_c.rd_sel     = 2'b01;
                case (fun3)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: dec_c.illegal = 1'b0;
                    3'b011, 3'b110:                         dec_c.illegal = (XLEN != 64);
                    default:                                dec_c.illegal = 1'b1;
                endcase
            end
            OP_STORE: begin
                dec_c.operand_b = 1'b1;
                dec_c.mem_en    = 1'b1;
                dec_c.store     = 1'b1;
                dec_c.imm_sel   = 2'b01;
                if (fun3 == 3'b011) dec_c.illegal = (XLEN != 64);
                else                dec_c.illegal = fun3[2];
            end
            OP_BRANCH: begin
                dec_c.operand_b = 1'b1;
                dec_c.branch    = 1'b1;
                dec_c.imm_sel   = 2'b10;
                dec_c.illegal   = (fun3[2:1] == 2'b01);
            end
            OP_JAL: begin
                dec_c.reg_write = 1'b1;
                dec_c.operand_b = 1'b1;
                dec_c.jal       = 1'b1;
                dec_c.imm_sel   = 2'b11;
                dec_c.rd_sel    = 2'b10;
            end
            OP_JALR: begin
                dec_c.reg_write = 1'b1;
                dec_c.operand_b = 1'b1;
                dec_c.jalr      = 1'b1;
                dec_c.rd_sel    = 2'b10;
                dec_c.illegal   = (fun3 != 3'b000);
            end
            default: dec_c.illegal = 1'b1;
        endcase

        // Illegal encodings reach execute with every strobe and code quiet
        if (dec_c.illegal) begin
            dec_c.alu_control = '0;
            dec_c.operand_b   = 1'b0;
            dec_c.reg_write   = 1'b0;
            dec_c.mem_to_reg  = 1'b0;
            dec_c.mem_en      = 1'b0;
            dec_c.load        = 1'b0;
            dec_c.store       = 1'b0;
            dec_c.branch      = 1'b0;
            dec_c.jal         = 1'b0;
            dec_c.jalr        = 1'b0;
            dec_c.imm_sel     = 2'b00;
            dec_c.rd_sel      = 2'b00;
        end

        case (dec_c.imm_sel)
            2'b00:   dec_c.imm = imm_i;
            2'b01:   dec_c.imm = imm_s;
            2'b10:   dec_c.imm = imm_b;
            default: dec_c.imm = imm_j;
        endcase
    end

    assign in_ready_c = !out_valid_q || bus.out_ready;
    assign capture_c  = bus.in_valid && in_ready_c;
    assign handoff_c  = out_valid_q && bus.out_ready;

    // Pipeline register and counter next-state; flush overrides capture and hold
    always_comb begin
        bundle_d    = bundle_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;
        if (handoff_c && !bundle_q.illegal && !bus.flush) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (capture_c) begin
            out_valid_d = 1'b1;
            bundle_d    = dec_c;
        end else if (handoff_c) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            bundle_q    <= '0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            bundle_q    <= bundle_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_pc      = bundle_q.pc;
    assign bus.rs1         = bundle_q.rs1;
    assign bus.rs2         = bundle_q.rs2;
    assign bus.rd          = bundle_q.rd;
    assign bus.fun3        = bundle_q.fun3;
    assign bus.imm         = bundle_q.imm;
    assign bus.alu_control = bundle_q.alu_control;
    assign bus.operand_b   = bundle_q.operand_b;
    assign bus.reg_write   = bundle_q.reg_write;
    assign bus.mem_to_reg  = bundle_q.mem_to_reg;
    assign bus.mem_en      = bundle_q.mem_en;
    assign bus.load        = bundle_q.load;
    assign bus.store       = bundle_q.store;
    assign bus.branch      = bundle_q.branch;
    assign bus.jal         = bundle_q.jal;
    assign bus.jalr        = bundle_q.jalr;
    assign bus.imm_sel     = bundle_q.imm_sel;
    assign bus.rd_sel      = bundle_q.rd_sel;
    assign bus.illegal     = bundle_q.illegal;
    assign decoded_cnt     = cnt_q;

endmodule
